// File: rtl/fitness_pkg.sv
// Shared widths, default thresholds and helpers for the fitness tracker blocks
// (step_tracker and the pulse generator that drives it).
package fitness_pkg;

    localparam int STEP_W = 14;
    localparam int RATE_W = 9;
    localparam int DIST_W = 8;
    localparam int RAW_W  = 20;

    localparam int COUNT_MAX_DEF   = 9999;
    localparam int HALF_MILE_DEF   = 1024;
    localparam int ACTIVE_RATE_DEF = 32;

    // Pulse-generator cadence modes; the tracker only counts edges but shares the encoding.
    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_WALK = 2'd1,
        MODE_JOG  = 2'd2,
        MODE_RUN  = 2'd3
    } pulse_mode_e;

    function automatic logic [RATE_W-1:0] sat_rate(input logic [RATE_W:0] v);
        return v[RATE_W] ? {RATE_W{1'b1}} : v[RATE_W-1:0];
    endfunction

    function automatic logic [DIST_W-1:0] sat_dist(input logic [RAW_W-1:0] units);
        return (units > RAW_W'((1 << DIST_W) - 1)) ? {DIST_W{1'b1}} : units[DIST_W-1:0];
    endfunction

endpackage

// File: rtl/step_tracker_if.sv
// Step-pulse link between the pulse generator (master) and step_tracker (slave).
// max_rate exists only when STEP_MAX_RATE_EN is defined.
interface step_tracker_if;
    import fitness_pkg::*;

    logic              start;
    logic              pulse;
    logic [STEP_W-1:0] step_count;
    logic              sat;
    logic [DIST_W-1:0] distance;
    logic [RATE_W-1:0] rate;
    logic [RATE_W-1:0] active_secs;
    logic              sec_tick;
`ifdef STEP_MAX_RATE_EN
    logic [RATE_W-1:0] max_rate;
`endif

    modport master (
        output start, pulse,
        input  step_count, sat, distance, rate, active_secs, sec_tick
`ifdef STEP_MAX_RATE_EN
        , input max_rate
`endif
    );

    modport slave (
        input  start, pulse,
        output step_count, sat, distance, rate, active_secs, sec_tick
`ifdef STEP_MAX_RATE_EN
        , output max_rate
`endif
    );

endinterface

// File: rtl/step_tracker_edge_detect.sv
// Three-flop synchroniser for the asynchronous step pulse plus a rising-edge strobe.
module step_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic [2:0] sync_r;

    // Shift chain: sync_r[0]=s1, sync_r[1]=s2, sync_r[2]=s3.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= 3'b000;
        end else begin
            sync_r <= {sync_r[1:0], d};
        end
    end

    assign rise = sync_r[1] & ~sync_r[2];

endmodule

// File: rtl/step_tracker.sv
// Step tracker: totals, half-mile distance, per-second rate and active-second count.
// Optional STEP_MAX_RATE_EN adds a peak-rate register on the max_rate port.
module step_tracker
    import fitness_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int COUNT_MAX   = COUNT_MAX_DEF,
    parameter int HALF_MILE   = HALF_MILE_DEF,
    parameter int ACTIVE_RATE = ACTIVE_RATE_DEF
) (
    input  logic           clk,
    input  logic           reset,
    step_tracker_if.slave  bus
);

    localparam int               CYC_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLK_HZ - 1);

    logic              rise_s;
    logic              step_s;
    logic              terminal_s;
    logic [RAW_W-1:0]  raw_next_s;
    logic [STEP_W-1:0] step_next_s;
    logic [RATE_W:0]   win_sum_s;
    logic [RATE_W-1:0] new_rate_s;

    logic [RAW_W-1:0]  raw_steps_r;
    logic [STEP_W-1:0] step_count_r;
    logic              sat_r;
    logic [DIST_W-1:0] distance_r;
    logic [CYC_W-1:0]  cyc_r;
    logic [RATE_W-1:0] win_steps_r;
    logic [RATE_W-1:0] rate_r;
    logic [RATE_W-1:0] active_secs_r;
    logic              sec_tick_r;

    step_edge_detect u_edge (
        .clk   (clk),
        .reset (reset),
        .d     (bus.pulse),
        .rise  (rise_s)
    );

    // Next-state values for the step totals and the closing-window rate.
    always_comb begin
        step_s     = rise_s & bus.start;
        terminal_s = (cyc_r == CYC_LAST);
        if (step_s && (raw_steps_r != {RAW_W{1'b1}})) begin
            raw_next_s = raw_steps_r + RAW_W'(1);
        end else begin
            raw_next_s = raw_steps_r;
        end
        if (step_s && (step_count_r != STEP_W'(COUNT_MAX))) begin
            step_next_s = step_count_r + STEP_W'(1);
        end else begin
            step_next_s = step_count_r;
        end
        win_sum_s  = {1'b0, win_steps_r} + {{RATE_W{1'b0}}, step_s};
        new_rate_s = sat_rate(win_sum_s);
    end

    // Running totals; distance follows raw_steps so it keeps moving after step_count saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            raw_steps_r  <= {RAW_W{1'b0}};
            step_count_r <= {STEP_W{1'b0}};
            sat_r        <= 1'b0;
            distance_r   <= {DIST_W{1'b0}};
        end else begin
            raw_steps_r  <= raw_next_s;
            step_count_r <= step_next_s;
            sat_r        <= sat_r | (step_next_s == STEP_W'(COUNT_MAX));
            distance_r   <= sat_dist(raw_next_s / RAW_W'(HALF_MILE));
        end
    end

    // One-second window; a step on the terminal cycle belongs to the window it closes.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_r         <= {CYC_W{1'b0}};
            win_steps_r   <= {RATE_W{1'b0}};
            rate_r        <= {RATE_W{1'b0}};
            active_secs_r <= {RATE_W{1'b0}};
            sec_tick_r    <= 1'b0;
        end else if (!bus.start) begin
            cyc_r       <= {CYC_W{1'b0}};
            win_steps_r <= {RATE_W{1'b0}};
            sec_tick_r  <= 1'b0;
        end else if (terminal_s) begin
            cyc_r       <= {CYC_W{1'b0}};
            win_steps_r <= {RATE_W{1'b0}};
            rate_r      <= new_rate_s;
            sec_tick_r  <= 1'b1;
            if ((new_rate_s > RATE_W'(ACTIVE_RATE)) && (active_secs_r != {RATE_W{1'b1}})) begin
                active_secs_r <= active_secs_r + RATE_W'(1);
            end else begin
                active_secs_r <= active_secs_r;
            end
        end else begin
            cyc_r       <= cyc_r + CYC_W'(1);
            win_steps_r <= new_rate_s;
            sec_tick_r  <= 1'b0;
        end
    end

`ifdef STEP_MAX_RATE_EN
    logic [RATE_W-1:0] max_rate_r;

    // Peak per-second rate since reset, refreshed only when a window closes.
    always_ff @(posedge clk) begin
        if (reset) begin
            max_rate_r <= {RATE_W{1'b0}};
        end else if (bus.start && terminal_s && (new_rate_s > max_rate_r)) begin
            max_rate_r <= new_rate_s;
        end else begin
            max_rate_r <= max_rate_r;
        end
    end

    assign bus.max_rate = max_rate_r;
`endif

    assign bus.step_count  = step_count_r;
    assign bus.sat         = sat_r;
    assign bus.distance    = distance_r;
    assign bus.rate        = rate_r;
    assign bus.active_secs = active_secs_r;
    assign bus.sec_tick    = sec_tick_r;

endmodule

// File: tb/tb_step_tracker.sv
// Directed bench for step_tracker with a 100-cycle window; max_rate checks follow STEP_MAX_RATE_EN.
module tb_step_tracker;
    import fitness_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   ec;
    int   n_cmp = 0;
    int   n_bad = 0;

    step_tracker_if sif ();

    step_tracker #(.CLK_HZ(100)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    always #5 clk = ~clk;

    task automatic clk1();
        @(posedge clk);
        #1;
        ec = ec + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp = n_cmp + 1;
        assert (obs === expv) else begin
            n_bad = n_bad + 1;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        sif.start = 1'b0;
        sif.pulse = 1'b0;
        repeat (3) clk1();
        reset = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".step_count"},  32'(sif.step_count),  32'd0);
        chk({tag, ".sat"},         32'(sif.sat),         32'd0);
        chk({tag, ".distance"},    32'(sif.distance),    32'd0);
        chk({tag, ".rate"},        32'(sif.rate),        32'd0);
        chk({tag, ".active_secs"}, 32'(sif.active_secs), 32'd0);
        chk({tag, ".sec_tick"},    32'(sif.sec_tick),    32'd0);
`ifdef STEP_MAX_RATE_EN
        chk({tag, ".max_rate"},    32'(sif.max_rate),    32'd0);
`endif
    endtask

    task automatic chk_max(input string tag, input int expv);
`ifdef STEP_MAX_RATE_EN
        chk(tag, 32'(sif.max_rate), 32'(expv));
`else
        if (tag.len() < 0) $display("%0d", expv);
`endif
    endtask

    // Period 2 until ec=297, then period 4 starting with a rise at 298.
    function automatic logic f_b(input int e);
        if (e < 298) return (e % 2 == 0);
        else         return ((e - 298) % 4 < 2);
    endfunction

    function automatic logic f_d(input int e);
        if (e == 277 || e == 279) return 1'b1;
        else return (e % 2 == 0) && ((e <= 38) || (e >= 60 && e <= 76) ||
                                     (e >= 80 && e <= 144) || (e >= 200 && e <= 262));
    endfunction

    initial begin
        ec = 0;
        // Single step latency
        do_reset();
        check_zero("rst");
        ec = 0;
        sif.start = 1'b1;
        while (ec < 14) begin
            clk1();
            sif.pulse = (ec == 9) || (ec == 10);
            if (ec == 11) chk("t1_latency", 32'(sif.step_count), 32'd0);
            if (ec == 12) begin
                chk("t1_count", 32'(sif.step_count), 32'd1);
                chk("t1_sat",   32'(sif.sat),        32'd0);
                chk("t1_dist",  32'(sif.distance),   32'd0);
            end
        end

        // 50/s for three seconds, 25/s for the fourth, then reset mid-window
        do_reset();
        ec = -10;
        sif.pulse = f_b(ec);
        while (ec < 455) begin
            clk1();
            if (ec == 0)   sif.start = 1'b1;
            if (ec == 450) reset = 1'b1;
            if (ec == 451) reset = 1'b0;
            sif.pulse = f_b(ec);
            if (ec == 99)  chk("t2_tick_pre", 32'(sif.sec_tick), 32'd0);
            if (ec == 100) begin
                chk("t2_tick1",   32'(sif.sec_tick),    32'd1);
                chk("t2_rate1",   32'(sif.rate),        32'd50);
                chk("t2_active1", 32'(sif.active_secs), 32'd1);
                chk_max("t2_max1", 50);
            end
            if (ec == 101) chk("t2_tick_post", 32'(sif.sec_tick), 32'd0);
            if (ec == 300) begin
                chk("t2_rate3",   32'(sif.rate),        32'd50);
                chk("t2_active3", 32'(sif.active_secs), 32'd3);
            end
            if (ec == 400) begin
                chk("t2_tick4",   32'(sif.sec_tick),    32'd1);
                chk("t2_rate4",   32'(sif.rate),        32'd25);
                chk("t2_active4", 32'(sif.active_secs), 32'd3);
                chk("t2_count4",  32'(sif.step_count),  32'd175);
                chk_max("t2_max4", 50);
            end
            if (ec == 451) check_zero("t6_reset");
        end

        // Saturation of step_count while distance keeps advancing
        do_reset();
        ec = 0;
        sif.start = 1'b1;
        sif.pulse = 1'b1;
        while (ec < 20010) begin
            clk1();
            sif.pulse = (ec % 2 == 0) && (ec <= 20000);
            if (ec == 2048) chk("t3_dist_1023", 32'(sif.distance), 32'd0);
            if (ec == 2049) chk("t3_dist_1024", 32'(sif.distance), 32'd1);
            if (ec == 19998) begin
                chk("t3_count_9998", 32'(sif.step_count), 32'd9998);
                chk("t3_sat_9998",   32'(sif.sat),        32'd0);
            end
            if (ec == 19999) begin
                chk("t3_count_9999", 32'(sif.step_count), 32'd9999);
                chk("t3_sat_9999",   32'(sif.sat),        32'd1);
            end
        end
        chk("t3_count_hold", 32'(sif.step_count),  32'd9999);
        chk("t3_sat_hold",   32'(sif.sat),         32'd1);
        chk("t3_dist",       32'(sif.distance),    32'd9);
        chk("t3_rate",       32'(sif.rate),        32'd50);
        chk("t3_active",     32'(sif.active_secs), 32'd200);

        // Start dropped mid-window, restart, terminal-cycle step, ACTIVE_RATE boundary
        do_reset();
        ec = 0;
        sif.start = 1'b1;
        sif.pulse = f_d(ec);
        while (ec < 382) begin
            clk1();
            if (ec == 60) sif.start = 1'b0;
            if (ec == 80) sif.start = 1'b1;
            sif.pulse = f_d(ec);
            if (ec == 60) chk("t4_count_drop", 32'(sif.step_count), 32'd20);
            if (ec == 80) chk("t4_count_low",  32'(sif.step_count), 32'd20);
            if (ec == 100) begin
                chk("t4_no_tick", 32'(sif.sec_tick), 32'd0);
                chk("t4_no_rate", 32'(sif.rate),     32'd0);
            end
            if (ec == 180) begin
                chk("t4_tick",   32'(sif.sec_tick),    32'd1);
                chk("t4_rate",   32'(sif.rate),        32'd33);
                chk("t4_active", 32'(sif.active_secs), 32'd1);
                chk("t4_count",  32'(sif.step_count),  32'd53);
                chk_max("t4_max", 33);
            end
            if (ec == 280) begin
                chk("t5_rate",   32'(sif.rate),        32'd33);
                chk("t5_active", 32'(sif.active_secs), 32'd2);
                chk("t5_count",  32'(sif.step_count),  32'd86);
            end
            if (ec == 281) chk("t5_tick_post", 32'(sif.sec_tick), 32'd0);
            if (ec == 380) begin
                chk("t5_next_tick",   32'(sif.sec_tick),    32'd1);
                chk("t5_next_rate",   32'(sif.rate),        32'd1);
                chk("t5_next_active", 32'(sif.active_secs), 32'd2);
                chk("t5_next_count",  32'(sif.step_count),  32'd87);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
